// File: rtl/atmega_int_ctrl_if.sv
// Interrupt handshake bundle between peripheral sources / core (master side)
// and the interrupt arbiter (slave side).
interface atmega_int_ctrl_if #(
    parameter int NUM_INTS = 8,
    parameter int VECT_W   = 8
);
    logic [NUM_INTS-1:0] int_src_i;
    logic [NUM_INTS-1:0] int_en_i;
    logic                gie_i;
    logic                int_take_i;
    logic                reti_i;
    logic                int_req_o;
    logic [VECT_W-1:0]   int_vect_o;
    logic [NUM_INTS-1:0] int_ack_o;
    logic [NUM_INTS-1:0] int_pend_o;
    logic                in_service_o;

    modport master (
        output int_src_i, int_en_i, gie_i, int_take_i, reti_i,
        input  int_req_o, int_vect_o, int_ack_o, int_pend_o, in_service_o
    );

    modport slave (
        input  int_src_i, int_en_i, gie_i, int_take_i, reti_i,
        output int_req_o, int_vect_o, int_ack_o, int_pend_o, in_service_o
    );
endinterface

// File: rtl/atmega_int_ctrl.sv
// Fixed-priority interrupt arbiter and vectoring stage for an AVR-style core:
// request -> take -> one-cycle ack -> service until RETI.
//
// state   | meaning
// IDLE    | no request outstanding, arbitrating pending sources
// PEND    | int_req_o raised, vector frozen, waiting for core take
// ACK     | one-cycle acknowledge to the winning source
// SERVICE | ISR running, new requests held off until RETI
module atmega_int_ctrl #(
    parameter int NUM_INTS    = 8,
    parameter int VECT_W      = 8,
    parameter int VECT_STRIDE = 2
) (
    input logic             clk_i,
    input logic             rst_i,
    atmega_int_ctrl_if.slave bus
);
    localparam int SEL_W = (NUM_INTS > 1) ? $clog2(NUM_INTS) : 1;

    typedef enum logic [1:0] {IDLE, PEND, ACK, SERVICE} state_t;

    state_t              state;
    logic [SEL_W-1:0]    sel;
    logic [SEL_W-1:0]    win_idx;
    logic [NUM_INTS-1:0] pending;
    logic                req_q;
    logic [VECT_W-1:0]   vect_q;
    logic [NUM_INTS-1:0] ack_q;
    logic [NUM_INTS-1:0] pend_q;
    logic                svc_q;

    assign bus.int_req_o    = req_q;
    assign bus.int_vect_o   = vect_q;
    assign bus.int_ack_o    = ack_q;
    assign bus.int_pend_o   = pend_q;
    assign bus.in_service_o = svc_q;

    assign pending = bus.int_src_i & bus.int_en_i;

    // Vector arithmetic wraps at VECT_W bits by design.
    function automatic logic [VECT_W-1:0] vector_of(input logic [SEL_W-1:0] idx);
        logic [31:0] v;
        v = (32'(idx) + 32'd1) * 32'(VECT_STRIDE);
        return v[VECT_W-1:0];
    endfunction

    // Lowest index wins: scan downwards so the last hit is the smallest.
    always_comb begin
        win_idx = '0;
        for (int k = NUM_INTS - 1; k >= 0; k--) begin
            if (pending[k]) win_idx = SEL_W'(k);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            sel    <= '0;
            req_q  <= 1'b0;
            vect_q <= '0;
            ack_q  <= '0;
            pend_q <= '0;
            svc_q  <= 1'b0;
        end else begin
            pend_q <= pending;
            ack_q  <= '0;
            case (state)
                IDLE: begin
                    if (bus.gie_i && (|pending)) begin
                        sel    <= win_idx;
                        req_q  <= 1'b1;
                        vect_q <= vector_of(win_idx);
                        state  <= PEND;
                    end
                end
                PEND: begin
                    // A take in the same cycle as a withdrawal still commits.
                    if (bus.int_take_i) begin
                        req_q      <= 1'b0;
                        ack_q[sel] <= 1'b1;
                        state      <= ACK;
                    end else if (!pending[sel] || !bus.gie_i) begin
                        req_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                ACK: begin
                    svc_q <= 1'b1;
                    state <= SERVICE;
                end
                SERVICE: begin
                    if (bus.reti_i) begin
                        svc_q <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    req_q <= 1'b0;
                    svc_q <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/atmega_int_ctrl.md
Name: atmega_int_ctrl

Overview:
- Interrupt arbiter/vectoring stage sitting directly downstream of the peripheral interrupt sources (RTC, timers, UART) and upstream of the AVR-style core.
- Collects level-held interrupt requests, applies per-source enables and the global I flag, and selects the highest-priority pending source.
- Presents its vector to the core, then returns a one-cycle acknowledge to the winning source, which clears that source's toggle-pair request.
- Holds off further interrupts until the core signals RETI.

Parameters:
- NUM_INTS, 8, number of interrupt sources (1..32).
- VECT_W, 8, width of vector address output.
- VECT_STRIDE, 2, vector spacing in words; vector for source k = (k+1)*VECT_STRIDE; vector 0 is reset.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- int_src_i  in  NUM_INTS  level requests; bit k held high until acked (e.g. rtc intr_o).
- int_en_i  in  NUM_INTS  per-source enable mask from register file.
- gie_i  in  1  global interrupt enable (SREG I bit).
- int_take_i  in  1  core single-cycle pulse: vector accepted, entering ISR.
- reti_i  in  1  core single-cycle pulse: RETI executed.
- int_req_o  out  1  interrupt request to core.
- int_vect_o  out  VECT_W  vector address of selected source.
- int_ack_o  out  NUM_INTS  one-hot, one-cycle acknowledge to winning source.
- int_pend_o  out  NUM_INTS  registered int_src_i & int_en_i, status readback.
- in_service_o  out  1  high while an ISR is active.

Behaviour:
- One clock and reset. Reset is synchronous, active-high: rst_i sampled on rising clk_i.
- All outputs are registered. Reset values:
  - int_req_o=0, int_vect_o=0, int_ack_o=0, int_pend_o=0, in_service_o=0.
  - Internal sel=0, state=IDLE.
- Reset mid-operation aborts any state and drops all outputs on the next edge; no ack is issued.
- pending = int_src_i & int_en_i, combinational. Priority: lowest index wins (fixed, AVR order).
- Vector arithmetic: (sel+1)*VECT_STRIDE, truncated to VECT_W bits (no saturation).
- States:
  - IDLE: if gie_i & |pending, latch sel = lowest set index; set int_req_o=1 and int_vect_o = vector(sel); go to PEND. Otherwise stay.
  - PEND: int_req_o=1; int_vect_o stable (no re-arbitration even if a higher priority arrives).
    - int_take_i: go to ACK, int_req_o=0.
    - Else, if pending[sel]=0 or gie_i=0 (request withdrawn/masked): int_req_o=0, go to IDLE.
    - int_take_i together with withdrawal: take wins, go to ACK.
  - ACK: int_ack_o[sel]=1 for exactly this one cycle; int_req_o=0; go to SERVICE.
  - SERVICE: in_service_o=1; int_ack_o=0; requests ignored. On reti_i: in_service_o=0, go to IDLE.
- Latency:
  - Pending source to int_req_o high: 1 cycle.
  - int_take_i to int_ack_o: 1 cycle.
  - reti_i to new int_req_o: ≥2 cycles (IDLE evaluates after return).
- Sources drop their request 1 cycle after seeing ack. The ACK→SERVICE→IDLE path takes ≥2 cycles, so the same event is never re-serviced.
- reti_i outside SERVICE and int_take_i outside PEND are ignored.
- gie_i dropping during SERVICE has no effect.

Test Plan:
- Reset: rst_i high 3 cycles with int_src_i=8'hFF, int_en_i=8'hFF, gie_i=1 -> all outputs 0 during reset; int_req_o=1, int_vect_o=2 one cycle after release.
- Single source: int_src_i[3]=1, en=8'hFF, gie=1 -> int_req_o=1, int_vect_o=8; pulse int_take_i -> next cycle int_ack_o=8'h08 for one cycle, then in_service_o=1; source drops; reti_i -> back to IDLE, int_req_o stays 0.
- Priority and no preemption: src=8'b1010_0000 -> vect=12 (source 5).
  - While in PEND, raise src[1] -> vect stays 12.
  - After take/ack/reti, src[1] is serviced next with vect=4.
- Masking/withdrawal: src[2]=1 while in PEND, then clear en[2] -> int_req_o=0 next cycle, no ack. Repeat with gie_i=0 -> same result. Clear en[2] and assert take in the same cycle -> ack issued.
- RTC integration: connect an rtc instance with PERIOD_STATIC=10 to src[0] and loop core handshakes -> exactly one ack per rtc period. Delay reti 25 cycles -> at most one pending request is serviced later, with no duplicate acks.
